clk_div_multi: RTL

Parametrised multi-channel clock divider, the successor to the team's single fixed divide-by-100,000,000 toggle divider. It generates NUM_CH independent divided clocks from one system clock. Each channel has a runtime-programmable half-period, an enable, and a one-cycle rising-edge strobe. It sits between the board oscillator and the display, scan and debounce logic that need slow clocks or enables. All state is synchronous to `clk`; there are no derived-clock resets and no asynchronous paths.

---
 rtl/clk_div_multi_if.sv | 26 ++
 rtl/clk_div_multi.sv | 91 +++++++++
 2 files changed

// File: rtl/clk_div_multi_if.sv
// Control and status bundle for the multi-channel clock divider.
// The master side programs enables and half-periods; the slave side (the
// divider) returns the divided clocks, rise strobes and pending flags.
interface clk_div_multi_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 26,
    parameter int unsigned SEL_W  = 2
);
    logic [NUM_CH-1:0] en;
    logic              div_load;
    logic [SEL_W-1:0]  div_sel;
    logic [CNT_W-1:0]  div_val;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;

    modport master (
        output en, div_load, div_sel, div_val,
        input  clk_out, tick, pend
    );

    modport slave (
        input  en, div_load, div_sel, div_val,
        output clk_out, tick, pend
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel counts eff = max(half, 1) system clocks per phase and toggles
// its output at the boundary. New half-periods are staged in nxt and only
// committed at a boundary (or while disabled) so no phase is ever shortened,
// except when the channel is disabled mid-phase.
module clk_div_multi #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 26,
    parameter int unsigned DEFAULT_HALF = 50000000,
    parameter int unsigned SEL_W        = 2
) (
    input logic            clk,
    input logic            rst_n,
    clk_div_multi_if.slave bus
);

    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [CNT_W-1:0]  half   [NUM_CH];
    logic [CNT_W-1:0]  nxt    [NUM_CH];
    logic [CNT_W-1:0]  eff_m1 [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] clk_q;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] load_hit;
    logic [NUM_CH-1:0] boundary;

    assign bus.clk_out = clk_q;
    assign bus.tick    = tick_q;
    assign bus.pend    = pend_q;

    // Decode the load request; an index at or beyond NUM_CH matches no channel.
    always_comb begin
        load_hit = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            load_hit[i] = bus.div_load && (32'(bus.div_sel) == i);
        end
    end

    // Terminal count per channel: a half-period of 0 behaves as 1.
    always_comb begin
        boundary = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            eff_m1[i]   = (half[i] == '0) ? '0 : half[i] - CNT_W'(1);
            boundary[i] = (cnt[i] == eff_m1[i]);
        end
    end

    // Per-channel counter, output toggle, strobe and staged half-period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i]  <= '0;
                half[i] <= CNT_W'(DEFAULT_HALF);
                nxt[i]  <= '0;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!bus.en[i]) begin
                    cnt[i]    <= '0;
                    clk_q[i]  <= 1'b0;
                    tick_q[i] <= 1'b0;
                    if (pend_q[i]) begin
                        half[i]   <= nxt[i];
                        pend_q[i] <= 1'b0;
                    end
                end else if (boundary[i]) begin
                    cnt[i]    <= '0;
                    clk_q[i]  <= ~clk_q[i];
                    tick_q[i] <= ~clk_q[i];
                    if (pend_q[i]) begin
                        half[i]   <= nxt[i];
                        pend_q[i] <= 1'b0;
                    end
                end else begin
                    cnt[i]    <= cnt[i] + CNT_W'(1);
                    tick_q[i] <= 1'b0;
                end
                // Placed last so a load coinciding with an apply commits the
                // old nxt to half while the new value stays pending.
                if (load_hit[i]) begin
                    nxt[i]    <= bus.div_val;
                    pend_q[i] <= 1'b1;
                end
            end
        end
    end

endmodule
